// File: rtl/jump_physics.sv
// Platformer jump physics: GROUND/AIR state machine advancing height and velocity once per tick.
// Optional macro JUMP_FASTFALL_EN adds extra gravity while ducking in the air.
module jump_physics #(
  parameter int W          = 11,
  parameter int G          = 1,
  parameter int JUMP_VEL   = 20,
  parameter int JUMP_CUT   = 8,
  parameter int MAX_FALL   = 20,
  parameter int FASTFALL_G = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         jump,
  input  logic         duck,
  output logic [W-1:0] height,
  output logic [W-1:0] velocity,
  output logic         airborne,
  output logic         landed
);

  localparam int XW = W + 2;
  localparam logic signed [XW-1:0] G_X        = XW'(G);
  localparam logic signed [XW-1:0] CUT_X      = XW'(JUMP_CUT);
  localparam logic signed [XW-1:0] NEG_FALL_X = XW'(-MAX_FALL);
  localparam logic signed [XW-1:0] H_MAX_X    = XW'((2 ** W) - 1);
  localparam logic signed [XW-1:0] ZERO_X     = '0;

  typedef enum logic {GROUND, AIR} state_t;

  state_t         state_reg;
  logic [W-1:0]   height_reg;
  logic [W-1:0]   velocity_reg;
  logic           airborne_reg;
  logic           landed_reg;
  logic           cut_done_reg;

  logic signed [XW-1:0] h_ext, v_ext, h_sum, v_grav, v_next, h_next, ff_term;
  logic                 cut_now;

`ifdef JUMP_FASTFALL_EN
  localparam logic signed [XW-1:0] FF_X = XW'(FASTFALL_G);
  assign ff_term = duck ? FF_X : ZERO_X;
`else
  logic unused_duck;
  assign unused_duck = duck;
  assign ff_term     = ZERO_X;
`endif

  always_comb begin
    h_ext   = $signed({2'b00, height_reg});
    v_ext   = $signed({{2{velocity_reg[W-1]}}, velocity_reg});
    h_sum   = h_ext + v_ext;
    // Early release caps upward speed once per jump, overriding gravity on that tick.
    cut_now = !jump && !cut_done_reg && (v_ext > CUT_X);
    v_grav  = v_ext - G_X - ff_term;
    v_next  = cut_now ? CUT_X : v_grav;
    if (v_next < NEG_FALL_X) v_next = NEG_FALL_X;
    h_next  = (h_sum > H_MAX_X) ? H_MAX_X : h_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= GROUND;
      height_reg   <= '0;
      velocity_reg <= '0;
      airborne_reg <= 1'b0;
      landed_reg   <= 1'b0;
      cut_done_reg <= 1'b0;
    end else begin
      landed_reg <= 1'b0;
      if (tick) begin
        case (state_reg)
          GROUND: begin
            height_reg <= '0;
            if (jump) begin
              velocity_reg <= W'(JUMP_VEL);
              airborne_reg <= 1'b1;
              cut_done_reg <= 1'b0;
              state_reg    <= AIR;
            end else begin
              velocity_reg <= '0;
            end
          end
          AIR: begin
            if (h_sum <= ZERO_X) begin
              height_reg   <= '0;
              velocity_reg <= '0;
              airborne_reg <= 1'b0;
              landed_reg   <= 1'b1;
              state_reg    <= GROUND;
            end else begin
              height_reg   <= h_next[W-1:0];
              velocity_reg <= v_next[W-1:0];
              if (cut_now) cut_done_reg <= 1'b1;
            end
          end
          default: state_reg <= GROUND;
        endcase
      end
    end
  end

  assign height   = height_reg;
  assign velocity = velocity_reg;
  assign airborne = airborne_reg;
  assign landed   = landed_reg;

endmodule

// File: tb/tb_jump_physics.sv
// Scoreboard bench for jump_physics: a reference model queues expected outputs per cycle.
module tb_jump_physics;
  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tick = 1'b0;
  logic         jump = 1'b0;
  logic         duck = 1'b0;
  logic [W-1:0] height;
  logic [W-1:0] velocity;
  logic         airborne;
  logic         landed;

  jump_physics dut (
    .clk(clk), .rst(rst), .tick(tick), .jump(jump), .duck(duck),
    .height(height), .velocity(velocity), .airborne(airborne), .landed(landed)
  );

  always #5 clk = ~clk;

  typedef struct {int h; int v; int air; int land;} exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int m_h = 0, m_v = 0, m_air = 0, m_land = 0, m_cut = 0;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int vel_now();
    return int'($signed(velocity));
  endfunction

  task automatic model_tick(input int j, input int d);
    int hn, vn, ff;
    m_land = 0;
    if (m_air == 0) begin
      m_h = 0;
      if (j != 0) begin m_v = 20; m_air = 1; m_cut = 0; end
      else m_v = 0;
    end else begin
      ff = 0;
`ifdef JUMP_FASTFALL_EN
      if (d != 0) ff = 3;
`endif
      hn = m_h + m_v;
      vn = m_v - 1 - ff;
      if (j == 0 && m_cut == 0 && m_v > 8) begin vn = 8; m_cut = 1; end
      if (vn < -20) vn = -20;
      if (hn <= 0) begin
        m_h = 0; m_v = 0; m_air = 0; m_land = 1;
      end else begin
        m_h = (hn > 2047) ? 2047 : hn;
        m_v = vn;
      end
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_h"}, int'(height), e.h);
    check({tag, "_v"}, vel_now(), e.v);
    check({tag, "_air"}, int'(airborne), e.air);
    check({tag, "_land"}, int'(landed), e.land);
    $display("%s: t=%0b j=%0b d=%0b h=%0d v=%0d air=%0b land=%0b",
             tag, tick, jump, duck, height, vel_now(), airborne, landed);
  endtask

  task automatic step(input string tag, input int t, input int j, input int d);
    exp_t e;
    @(negedge clk);
    rst = 1'b0; tick = (t != 0); jump = (j != 0); duck = (d != 0);
    if (t != 0) model_tick(j, d);
    else m_land = 0;
    e.h = m_h; e.v = m_v; e.air = m_air; e.land = m_land;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
    tick = 1'b0;
  endtask

  task automatic do_reset(input string tag, input int t, input int j);
    exp_t e;
    @(negedge clk);
    rst = 1'b1; tick = (t != 0); jump = (j != 0); duck = 1'b0;
    m_h = 0; m_v = 0; m_air = 0; m_land = 0; m_cut = 0;
    e.h = 0; e.v = 0; e.air = 0; e.land = 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
    rst = 1'b0; tick = 1'b0; jump = 1'b0;
  endtask

  task automatic fall_to_ground(input string tag);
    int n;
    n = 0;
    while (airborne && n < 200) begin
      step(tag, 1, 0, 0);
      n++;
    end
    check({tag, "_landed_in_time"}, int'(airborne), 0);
  endtask

  initial begin
    int land_seen;
    int ev;
    do_reset("reset", 0, 0);
    do_reset("reset_prio", 1, 1);

    // full jump with jump held throughout; relaunch on the tick after landing
    step("launch", 1, 1, 0);
    for (int n = 1; n <= 41; n++) begin
      step($sformatf("hold%0d", n), 1, 1, 0);
      if (n <= 20) check($sformatf("hold_h%0d", n), int'(height), 20 * n - (n * (n - 1)) / 2);
      if (n == 20) check("apex_v", vel_now(), 0);
    end
    check("touch_land", int'(landed), 1);
    check("touch_air", int'(airborne), 0);
    check("touch_h", int'(height), 0);
    step("relaunch", 1, 1, 0);
    check("relaunch_v", vel_now(), 20);
    check("relaunch_air", int'(airborne), 1);

    // short hop: release after first air tick
    do_reset("reset2", 0, 0);
    step("sh_launch", 1, 1, 0);
    step("sh1", 1, 1, 0);
    check("sh1_hv", int'(height) * 100 + vel_now(), 20 * 100 + 19);
    step("sh2", 1, 0, 0);
    check("sh2_hv", int'(height) * 100 + vel_now(), 39 * 100 + 8);
    step("sh3", 1, 0, 0);
    check("sh3_hv", int'(height) * 100 + vel_now(), 47 * 100 + 7);
    fall_to_ground("sh_fall");
    step("land_idle", 0, 0, 0);

    // reset mid-jump after tick 10
    step("rj_launch", 1, 1, 0);
    land_seen = 0;
    for (int n = 1; n <= 10; n++) begin
      step($sformatf("rj%0d", n), 1, 1, 0);
      if (landed) land_seen = 1;
    end
    do_reset("rj_reset", 0, 0);
    check("rj_no_land", land_seen | int'(landed), 0);

    // duck from apex
    step("ff_launch", 1, 1, 0);
    for (int n = 1; n <= 20; n++) step($sformatf("ffup%0d", n), 1, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      step($sformatf("ff%0d", k), 1, 1, 1);
`ifdef JUMP_FASTFALL_EN
      ev = (-4 * k < -20) ? -20 : -4 * k;
`else
      ev = -k;
`endif
      check($sformatf("ff_v%0d", k), vel_now(), ev);
    end
    fall_to_ground("ff_fall");

    // duck on ground does nothing
    step("gnd_duck", 1, 0, 1);

    // freeze while airborne with no ticks
    step("fz_launch", 1, 1, 0);
    for (int n = 1; n <= 5; n++) step($sformatf("fzup%0d", n), 1, 1, 0);
    for (int n = 0; n < 100; n++) step($sformatf("freeze%0d", n), 0, 0, 1);
    step("fz_resume", 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jump_physics.md
JUMP_PHYSICS -- requirements
Module: jump_physics

Interface
REQ-001 The block SHALL have parameter W, default 11: width of height and velocity.
REQ-002 The block SHALL have parameter G, default 1: gravity step subtracted from velocity per tick.
REQ-003 The block SHALL have parameter JUMP_VEL, default 20: upward launch velocity.
REQ-004 The block SHALL have parameter JUMP_CUT, default 8: velocity cap applied on early jump release.
REQ-005 The block SHALL have parameter MAX_FALL, default 20: magnitude limit of downward velocity.
REQ-006 The block SHALL have parameter FASTFALL_G, default 3: extra gravity while ducking airborne.
REQ-007 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port tick, input, 1 bit: one-cycle frame strobe; physics advances only on cycles where tick=1.
REQ-010 The block SHALL have port jump, input, 1 bit: jump button, level.
REQ-011 The block SHALL have port duck, input, 1 bit: duck button, level.
REQ-012 The block SHALL have port height, output, W bits: unsigned height above ground, 0 = on ground.
REQ-013 The block SHALL have port velocity, output, W bits: signed two's-complement velocity, positive = upward.
REQ-014 The block SHALL have port airborne, output, 1 bit: high while in state AIR.
REQ-015 The block SHALL have port landed, output, 1 bit: one-cycle pulse on the touchdown update.

Function
REQ-016 The block SHALL implement two states, GROUND and AIR; outputs SHALL be registered.
REQ-017 The block SHALL hold all state and outputs on non-tick cycles, except that landed SHALL deassert.
REQ-018 On a GROUND tick with jump=1, the block SHALL set velocity to JUMP_VEL, keep height at 0, and enter AIR.
REQ-019 On a GROUND tick with jump=0, the block SHALL hold height=0 and velocity=0.
REQ-020 On an AIR tick, the block SHALL compute h' = height + velocity and v' = velocity - G - (fast-fall term per REQ-031).
REQ-021 If jump=0 on an AIR tick and velocity > JUMP_CUT, the block SHALL set v' to JUMP_CUT instead of REQ-020's v'; the short-hop cut SHALL be applied once per jump and SHALL win over gravity on that tick.
REQ-022 The block SHALL clamp v' to be no less than -MAX_FALL.
REQ-023 If h' <= 0, the block SHALL set height=0 and velocity=0, enter GROUND, and pulse landed.
REQ-024 Jump SHALL be sampled only on a GROUND tick; jump high on the landing tick SHALL NOT relaunch, and relaunch SHALL occur at the earliest on the next tick.
REQ-025 The block SHALL evaluate arithmetic in W+2-bit signed intermediates; h' above 2^W-1 SHALL saturate to 2^W-1.
REQ-026 Duck SHALL have no effect in GROUND.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL set state=GROUND, height=0, velocity=0, airborne=0, and landed=0, regardless of tick.
REQ-028 Reset mid-jump SHALL abort the jump immediately, without a landed pulse.
REQ-029 Reset SHALL take priority over tick.

Configuration
REQ-030 The block SHALL provide macro JUMP_FASTFALL_EN.
REQ-031 When JUMP_FASTFALL_EN is defined, duck=1 on an AIR tick SHALL add FASTFALL_G to the gravity subtraction, with the MAX_FALL clamp still applied.
REQ-032 When JUMP_FASTFALL_EN is undefined, the fast-fall term SHALL be 0, duck SHALL be ignored, and the port SHALL remain present.

Verification
REQ-033 With default parameters, jump held for one tick then held high, ticks 1..20 SHALL yield height 20,39,...,210 and velocity 0 at tick 20; tick 41 SHALL give height=0, landed=1, airborne=0.
REQ-034 With jump high on tick 1 only, tick 1 SHALL give height=20, velocity=19; tick 2 SHALL give height=39, velocity=8 (cut); tick 3 SHALL give height=47, velocity=7.
REQ-035 Asserting rst on the cycle after tick 10 of a jump SHALL give, next cycle, height=0, velocity=0, airborne=0, and landed never asserted.
REQ-036 With jump held continuously through landing, the landing tick SHALL give velocity=0 and GROUND, and the following tick SHALL give velocity=20 and airborne=1.
REQ-037 With JUMP_FASTFALL_EN defined and duck=1 from apex (tick 20), velocity SHALL step 0, -4, -8, ..., then clamp at -20; without the macro, velocity SHALL step 0, -1, -2, ....
REQ-038 With tick=0 for 100 cycles while airborne, all outputs SHALL be frozen and landed SHALL stay 0.
